// File: rtl/sprite_compositor_if.sv
// Register-write bus for the sprite compositor: the host drives the strobe,
// address and data, and the compositor flags writes to unmapped addresses.
interface sprite_compositor_if #(
  parameter int AW    = 4,
  parameter int CORDW = 16
) ();
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CORDW-1:0] wr_data;
  logic             wr_err;

  modport master (output wr_en, wr_addr, wr_data, input wr_err);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_err);
endinterface

// File: rtl/sprite_compositor.sv
// Fixed-priority sprite compositor with double-buffered position/enable registers
// (committed on the frame pulse) and per-frame collision reporting.
module sprite_compositor #(
  parameter int               NUM_SPR    = 3,
  parameter int               CORDW      = 16,
  parameter int               CIDXW      = 4,
  parameter logic [CIDXW-1:0] TRANS_INDX = 4'hF,
  parameter int               AW         = 4
) (
  input  logic                     clk_25MHz,
  input  logic                     btn_rst_n,
  input  logic                     frame,
  input  logic                     bright,
  sprite_compositor_if.slave       bus,
  input  logic [NUM_SPR-1:0]       spr_draw,
  input  logic [NUM_SPR*CIDXW-1:0] spr_pix,
  output logic [NUM_SPR*CORDW-1:0] spr_x,
  output logic [NUM_SPR*CORDW-1:0] spr_y,
  output logic [CIDXW-1:0]         pix_idx,
  output logic                     pix_opaque,
  output logic [2:0]               pix_src,
  output logic [NUM_SPR-1:0]       coll_flags,
  output logic                     coll_valid
);

  localparam logic [AW-1:0] EN_ADDR = AW'(2 * NUM_SPR);

  logic [CORDW-1:0]   r_shadowX [NUM_SPR];
  logic [CORDW-1:0]   r_shadowY [NUM_SPR];
  logic [CORDW-1:0]   r_activeX [NUM_SPR];
  logic [CORDW-1:0]   r_activeY [NUM_SPR];
  logic [NUM_SPR-1:0] r_shadowEn;
  logic [NUM_SPR-1:0] r_activeEn;
  logic [NUM_SPR-1:0] r_collAccum;
  logic [NUM_SPR-1:0] r_collFlags;
  logic               r_collValid;
  logic               r_wrErr;
  logic [CIDXW-1:0]   r_pixIdx;
  logic               r_pixOpaque;
  logic [2:0]         r_pixSrc;

  logic [NUM_SPR-1:0] w_opaque;
  logic [3:0]         w_opaqueCount;
  logic               w_multi;
  logic [CIDXW-1:0]   w_winIdx;
  logic [2:0]         w_winSrc;
  logic               w_anyOpaque;

  // The commit reads shadow values before this edge's write lands, so a write
  // coinciding with frame only takes effect at the following frame.
  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      for (int k = 0; k < NUM_SPR; k++) begin
        r_shadowX[k] <= '0;
        r_shadowY[k] <= '0;
        r_activeX[k] <= '0;
        r_activeY[k] <= '0;
      end
      r_shadowEn <= '1;
      r_activeEn <= '1;
      r_wrErr    <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        for (int k = 0; k < NUM_SPR; k++) begin
          if (bus.wr_addr == AW'(2 * k))     r_shadowX[k] <= bus.wr_data;
          if (bus.wr_addr == AW'(2 * k + 1)) r_shadowY[k] <= bus.wr_data;
        end
        if (bus.wr_addr == EN_ADDR) r_shadowEn <= bus.wr_data[NUM_SPR-1:0];
      end
      if (frame) begin
        for (int k = 0; k < NUM_SPR; k++) begin
          r_activeX[k] <= r_shadowX[k];
          r_activeY[k] <= r_shadowY[k];
        end
        r_activeEn <= r_shadowEn;
      end
      r_wrErr <= bus.wr_en && (bus.wr_addr > EN_ADDR);
    end
  end

  // Scanning from the highest index down leaves the lowest opaque sprite as winner.
  always_comb begin
    w_opaque      = '0;
    w_opaqueCount = '0;
    w_winIdx      = TRANS_INDX;
    w_winSrc      = '0;
    w_anyOpaque   = 1'b0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      w_opaque[k] = bright && spr_draw[k] && r_activeEn[k] &&
                    (spr_pix[k*CIDXW +: CIDXW] != TRANS_INDX);
      w_opaqueCount = w_opaqueCount + 4'(w_opaque[k]);
      if (w_opaque[k]) begin
        w_winIdx    = spr_pix[k*CIDXW +: CIDXW];
        w_winSrc    = 3'(k);
        w_anyOpaque = 1'b1;
      end
    end
    w_multi = (w_opaqueCount > 4'd1);
  end

  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_pixIdx    <= TRANS_INDX;
      r_pixOpaque <= 1'b0;
      r_pixSrc    <= '0;
    end else begin
      r_pixIdx    <= w_winIdx;
      r_pixOpaque <= w_anyOpaque;
      r_pixSrc    <= w_winSrc;
    end
  end

  // The frame cycle's own overlaps are dropped: the accumulator restarts empty.
  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_collAccum <= '0;
      r_collFlags <= '0;
      r_collValid <= 1'b0;
    end else begin
      r_collValid <= frame;
      if (frame) begin
        r_collFlags <= r_collAccum;
        r_collAccum <= '0;
      end else if (w_multi) begin
        r_collAccum <= r_collAccum | w_opaque;
      end
    end
  end

  always_comb begin
    spr_x = '0;
    spr_y = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      spr_x[k*CORDW +: CORDW] = r_activeX[k];
      spr_y[k*CORDW +: CORDW] = r_activeY[k];
    end
  end

  assign pix_idx    = r_pixIdx;
  assign pix_opaque = r_pixOpaque;
  assign pix_src    = r_pixSrc;
  assign coll_flags = r_collFlags;
  assign coll_valid = r_collValid;
  assign bus.wr_err = r_wrErr;

endmodule
